// File: rtl/write_leds.sv
// Serial shifter for a 74HC595-style SIPO chain: shifts WIDTH bits MSB first on shcp,
// then pulses stcp to latch the chain. All outputs are registered.
module write_leds #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HALF         = 4,
  parameter int unsigned LATCH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iniciar,
  input  logic [WIDTH-1:0] datos,
  output logic             ds,
  output logic             shcp,
  output logic             stcp,
  output logic             busy,
  output logic             finish
);

  localparam int unsigned TMAX = (HALF > LATCH_CYCLES) ? HALF : LATCH_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] HALF_LD  = TW'(HALF - 1);
  localparam logic [TW-1:0] LATCH_LD = TW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LD   = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ds_q, ds_d;
  logic             shcp_q, shcp_d;
  logic             stcp_q, stcp_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ds_q     <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ds_q     <= ds_d;
      shcp_q   <= shcp_d;
      stcp_q   <= stcp_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  // Timer counts down from a preload; the phase ends on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (iniciar) begin
          shreg_d = datos;
          cnt_d   = CNT_LD;
          timer_d = HALF_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == '0) begin
          timer_d = HALF_LD;
          state_d = HIGH;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HIGH: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (cnt_q != '0) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
          timer_d = HALF_LD;
          state_d = SETUP;
        end else begin
          timer_d = LATCH_LD;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ds_d     = 1'b0;
    shcp_d   = 1'b0;
    stcp_d   = 1'b0;
    busy_d   = 1'b0;
    finish_d = 1'b0;
    unique case (state_d)
      SETUP: begin
        ds_d   = shreg_d[WIDTH-1];
        busy_d = 1'b1;
      end
      HIGH: begin
        ds_d   = shreg_d[WIDTH-1];
        shcp_d = 1'b1;
        busy_d = 1'b1;
      end
      LATCH: begin
        stcp_d = 1'b1;
        busy_d = 1'b1;
      end
      DONE: begin
        finish_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: begin
        ds_d = 1'b0;
      end
    endcase
  end

  assign ds     = ds_q;
  assign shcp   = shcp_q;
  assign stcp   = stcp_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_write_leds.sv
// Bench for write_leds: a default 8-bit instance and a 16-bit/HALF=1/LATCH=1 instance,
// each compared every cycle against a timeline model and a 74HC595 chain model.
module tb_write_leds;

  localparam int unsigned TOT8  = 2 * 4 * 8 + 4 + 1;
  localparam int unsigned TOT16 = 2 * 1 * 16 + 1 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ini8, ini16;
  logic [7:0]  dat8;
  logic [15:0] dat16;
  logic        ds8, sh8, st8, bz8, fn8;
  logic        ds16, sh16, st16, bz16, fn16;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  write_leds dut8 (
    .clk(clk), .rst(rst), .iniciar(ini8), .datos(dat8),
    .ds(ds8), .shcp(sh8), .stcp(st8), .busy(bz8), .finish(fn8)
  );

  write_leds #(.WIDTH(16), .HALF(1), .LATCH_CYCLES(1)) dut16 (
    .clk(clk), .rst(rst), .iniciar(ini16), .datos(dat16),
    .ds(ds16), .shcp(sh16), .stcp(st16), .busy(bz16), .finish(fn16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {ds,shcp,stcp,busy,finish} t cycles after the accepting edge.
  function automatic logic [4:0] expv(input int unsigned w, input int unsigned h,
                                      input int unsigned l, input logic [15:0] d,
                                      input int unsigned t);
    int unsigned b;
    if (t < 2 * h * w) begin
      b = t / (2 * h);
      return {d[w-1-b], ((t % (2 * h)) >= h), 1'b0, 1'b1, 1'b0};
    end else if (t < 2 * h * w + l) begin
      return 5'b00110;
    end
    return 5'b00011;
  endfunction

  // 74HC595 chain models
  logic [7:0]  chain8 = '0, lat8 = '0;
  logic [15:0] chain16 = '0, lat16 = '0;
  int unsigned rises8 = 0, stcpr8 = 0, rises16 = 0, stcpr16 = 0;

  always @(posedge sh8)  begin chain8  = {chain8[6:0], ds8};    rises8++;  end
  always @(posedge st8)  begin lat8    = chain8;                stcpr8++;  end
  always @(posedge sh16) begin chain16 = {chain16[14:0], ds16}; rises16++; end
  always @(posedge st16) begin lat16   = chain16;               stcpr16++; end

  // Model state and DUT-observed event records
  int unsigned edge8 = 0, s8 = 0, stcyc8 = 0, dfin8 = 0, dfe8 = 0, dbe8 = 0;
  int unsigned edge16 = 0, s16 = 0, stcyc16 = 0, dfin16 = 0, dfe16 = 0, dbe16 = 0;
  bit          act8 = 1'b0, act16 = 1'b0;
  logic [15:0] d8 = '0, d16 = '0;
  logic        pds8 = 1'b0, psh8 = 1'b0, pfn8 = 1'b0, pbz8 = 1'b0;
  logic        pds16 = 1'b0, psh16 = 1'b0, pfn16 = 1'b0, pbz16 = 1'b0;

  always @(posedge clk) begin
    logic [4:0] e;
    edge8++;
    if (!rst) act8 = 1'b0;
    else if (!act8 || (edge8 - s8 > TOT8)) begin
      act8 = 1'b0;
      if (ini8) begin act8 = 1'b1; s8 = edge8; d8 = {8'h00, dat8}; end
    end
    e = (act8 && (edge8 - s8 < TOT8)) ? expv(8, 4, 4, d8, edge8 - s8) : 5'b0;
    #1;
    chk("out8", 32'({ds8, sh8, st8, bz8, fn8}), 32'(e));
    if (e[0]) chk("latch8", 32'(lat8), 32'(d8[7:0]));
    if (sh8 && psh8) chk("ds_hold8", 32'(ds8), 32'(pds8));
    chk("fin_twice8", 32'(fn8 && pfn8), 32'(0));
    chk("stcp_shcp8", 32'(st8 && sh8), 32'(0));
    if (st8) stcyc8++;
    if (fn8) begin dfin8++; dfe8 = edge8; end
    if (bz8 && !pbz8) dbe8 = edge8;
    pds8 = ds8; psh8 = sh8; pfn8 = fn8; pbz8 = bz8;
  end

  always @(posedge clk) begin
    logic [4:0] e;
    edge16++;
    if (!rst) act16 = 1'b0;
    else if (!act16 || (edge16 - s16 > TOT16)) begin
      act16 = 1'b0;
      if (ini16) begin act16 = 1'b1; s16 = edge16; d16 = dat16; end
    end
    e = (act16 && (edge16 - s16 < TOT16)) ? expv(16, 1, 1, d16, edge16 - s16) : 5'b0;
    #1;
    chk("out16", 32'({ds16, sh16, st16, bz16, fn16}), 32'(e));
    if (e[0]) chk("latch16", 32'(lat16), 32'(d16));
    if (sh16 && psh16) chk("ds_hold16", 32'(ds16), 32'(pds16));
    chk("fin_twice16", 32'(fn16 && pfn16), 32'(0));
    chk("stcp_shcp16", 32'(st16 && sh16), 32'(0));
    if (st16) stcyc16++;
    if (fn16) begin dfin16++; dfe16 = edge16; end
    if (bz16 && !pbz16) dbe16 = edge16;
    pds16 = ds16; psh16 = sh16; pfn16 = fn16; pbz16 = bz16;
  end

  task automatic wait_fin(input bit wide, input int unsigned lim);
    int unsigned n;
    n = wide ? dfin16 : dfin8;
    for (int unsigned i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((wide ? dfin16 : dfin8) != n) return;
    end
    chk(wide ? "finish16_timeout" : "finish8_timeout", 32'(1), 32'(0));
  endtask

  task automatic start8(input logic [7:0] v);
    @(negedge clk);
    ini8 = 1'b1;
    dat8 = v;
    @(negedge clk);
    ini8 = 1'b0;
  endtask

  initial begin
    int unsigned r0, sc0, c0, f;
    rst = 1'b0; ini8 = 1'b0; ini16 = 1'b0; dat8 = '0; dat16 = '0;

    // hand-computed pins on the timeline model
    chk("model_t0", 32'(expv(8, 4, 4, 16'h00A5, 0)), 32'h12);
    chk("model_t8", 32'(expv(8, 4, 4, 16'h00A5, 8)), 32'h02);
    chk("model_t68", 32'(expv(8, 4, 4, 16'h00A5, 68)), 32'h03);
    chk("model16_t1", 32'(expv(16, 1, 1, 16'h8001, 1)), 32'h1A);

    repeat (3) @(negedge clk);
    chk("reset_out8", 32'({ds8, sh8, st8, bz8, fn8}), 32'(0));
    chk("reset_out16", 32'({ds16, sh16, st16, bz16, fn16}), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // A5 single transfer
    r0 = rises8; sc0 = stcpr8; c0 = stcyc8;
    start8(8'hA5);
    wait_fin(1'b0, 200);
    chk("a5_rises", rises8 - r0, 8);
    chk("a5_stcp_edges", stcpr8 - sc0, 1);
    chk("a5_stcp_width", stcyc8 - c0, 4);
    chk("a5_latched", 32'(lat8), 32'hA5);
    // accept edge k: finish cycle k+69 is the one following edge k+68
    chk("a5_latency", dfe8 - dbe8, 68);

    // 00 then FF with iniciar held
    @(negedge clk);
    ini8 = 1'b1; dat8 = 8'h00;
    @(negedge clk);
    dat8 = 8'hFF;
    wait_fin(1'b0, 200);
    chk("b2b_first", 32'(lat8), 32'h00);
    f = dfe8;
    @(negedge clk);
    chk("b2b_idle_gap", 32'(bz8), 32'(0));
    @(negedge clk);
    chk("b2b_restart", 32'(bz8), 32'(1));
    chk("b2b_restart_edge", dbe8 - f, 2);
    ini8 = 1'b0;
    wait_fin(1'b0, 200);
    chk("b2b_second", 32'(lat8), 32'hFF);

    // 81 with a stray request carrying 3C mid-transfer
    start8(8'h81);
    repeat (20) @(negedge clk);
    ini8 = 1'b1; dat8 = 8'h3C;
    @(negedge clk);
    ini8 = 1'b0;
    wait_fin(1'b0, 200);
    chk("ignore_latched", 32'(lat8), 32'h81);
    sc0 = stcpr8;
    repeat (80) @(negedge clk);
    chk("ignore_no_second", stcpr8 - sc0, 0);

    // reset during the 5th bit's high phase
    sc0 = stcpr8;
    r0 = rises8;
    start8(8'hC3);
    for (int unsigned i = 0; i < 300 && (rises8 - r0) < 5; i++) @(negedge clk);
    chk("abort_bit5_reached", rises8 - r0, 5);
    chk("abort_in_high", 32'(sh8), 32'(1));
    #2 rst = 1'b0;
    #1 chk("abort_outputs", 32'({ds8, sh8, st8, bz8, fn8}), 32'(0));
    @(negedge clk);
    chk("abort_no_stcp", stcpr8 - sc0, 0);
    chk("abort_latched_kept", 32'(lat8), 32'h81);
    rst = 1'b1;
    start8(8'h5A);
    wait_fin(1'b0, 200);
    chk("after_abort", 32'(lat8), 32'h5A);

    // 16-bit fast instance
    r0 = rises16;
    @(negedge clk);
    ini16 = 1'b1; dat16 = 16'h8001;
    @(negedge clk);
    ini16 = 1'b0;
    wait_fin(1'b1, 100);
    chk("w16_rises", rises16 - r0, 16);
    chk("w16_latched", 32'(lat16), 32'h8001);
    chk("w16_latency", dfe16 - dbe16, 33);

    // randomized traffic on both instances
    for (int unsigned i = 0; i < 3000; i++) begin
      @(negedge clk);
      ini8  = ($urandom_range(0, 7) == 0);
      dat8  = 8'($urandom);
      ini16 = ($urandom_range(0, 5) == 0);
      dat16 = 16'($urandom);
    end
    @(negedge clk);
    ini8 = 1'b0; ini16 = 1'b0;
    repeat (100) @(negedge clk);
    chk("end_idle8", 32'(bz8), 32'(0));
    chk("end_idle16", 32'(bz16), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
